// File: rtl/nvdla_cmac_dual_group_ctrl.sv
// Ping-pong register group sequencer for CMAC: tracks per-group op_en, owns the
// consumer pointer, launches the MAC datapath and flips groups on layer completion.
module nvdla_cmac_dual_group_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             nvdla_core_clk,
   input  logic             nvdla_core_rstn,
   input  logic             op_en_wr_0,
   input  logic             op_en_wr_1,
   input  logic             op_en_wr_data,
   input  logic             sw_abort,
   input  logic             dp_done,
   output logic             consumer,
   output logic [1:0]       status_0,
   output logic [1:0]       status_1,
   output logic             op_en_0,
   output logic             op_en_1,
   output logic             dp_start,
   output logic             dp_group,
   output logic             dp_busy,
   output logic [1:0]       intr_done,
   output logic [CNT_W-1:0] done_cnt,
   output logic             err_unexp_done
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_BUSY  = 2'd2;

   logic [1:0]       r_state;
   logic [1:0]       r_op_en;
   logic             r_consumer;
   logic [1:0]       r_intr_done;
   logic [CNT_W-1:0] r_done_cnt;
   logic             r_err;

   logic             w_complete;
   logic             w_unexp;
   logic [1:0]       w_set;
   logic [1:0]       w_clr;

   assign w_complete = (r_state == ST_BUSY) && dp_done;
   assign w_unexp    = dp_done && (r_state != ST_BUSY);
   assign w_set      = {op_en_wr_1 & op_en_wr_data, op_en_wr_0 & op_en_wr_data};
   // Completion retires the consumer group; a same-cycle SW set still wins.
   assign w_clr      = w_complete ? (r_consumer ? 2'b10 : 2'b01) : 2'b00;

   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         r_state     <= ST_IDLE;
         r_op_en     <= 2'b00;
         r_consumer  <= 1'b0;
         r_intr_done <= 2'b00;
         r_done_cnt  <= '0;
         r_err       <= 1'b0;
      end else if (sw_abort) begin
         r_state     <= ST_IDLE;
         r_op_en     <= 2'b00;
         r_consumer  <= 1'b0;
         r_intr_done <= 2'b00;
         r_done_cnt  <= '0;
         r_err       <= 1'b0;
      end else begin
         r_op_en     <= w_set | (r_op_en & ~w_clr);
         r_intr_done <= w_clr;
         if (w_complete) begin
            r_consumer <= ~r_consumer;
            r_done_cnt <= r_done_cnt + CNT_W'(1);
         end
         if (w_unexp) begin
            r_err <= 1'b1;
         end
         case (r_state)
            ST_IDLE:  r_state <= r_op_en[r_consumer] ? ST_START : ST_IDLE;
            ST_START: r_state <= ST_BUSY;
            ST_BUSY:  r_state <= dp_done ? ST_IDLE : ST_BUSY;
            default:  r_state <= ST_IDLE;
         endcase
      end
   end

   assign consumer       = r_consumer;
   assign op_en_0        = r_op_en[0];
   assign op_en_1        = r_op_en[1];
   assign status_0       = !r_op_en[0] ? 2'd0 : (r_consumer == 1'b0) ? 2'd1 : 2'd2;
   assign status_1       = !r_op_en[1] ? 2'd0 : (r_consumer == 1'b1) ? 2'd1 : 2'd2;
   assign dp_start       = (r_state == ST_START);
   assign dp_busy        = (r_state == ST_START) || (r_state == ST_BUSY);
   assign dp_group       = r_consumer;
   assign intr_done      = r_intr_done;
   assign done_cnt       = r_done_cnt;
   assign err_unexp_done = r_err;

endmodule

// File: tb/tb_nvdla_cmac_dual_group_ctrl.sv
// Self-checking bench for nvdla_cmac_dual_group_ctrl: directed vector table,
// corner-case sequences and random traffic against a behavioural model.
module tb_nvdla_cmac_dual_group_ctrl;

   localparam int CNT_W = 4;
   localparam int CNT_MOD = 1 << CNT_W;

   logic             clk;
   logic             rstn;
   logic             wr0, wr1, wrData, abortIn, doneIn;
   logic             consumer, opEn0, opEn1, dpStart, dpGroup, dpBusy, errUnexp;
   logic [1:0]       status0, status1, intrDone;
   logic [CNT_W-1:0] doneCnt;

   int checks = 0;
   int failures = 0;

   nvdla_cmac_dual_group_ctrl #(.CNT_W(CNT_W)) dut (
      .nvdla_core_clk (clk),
      .nvdla_core_rstn(rstn),
      .op_en_wr_0     (wr0),
      .op_en_wr_1     (wr1),
      .op_en_wr_data  (wrData),
      .sw_abort       (abortIn),
      .dp_done        (doneIn),
      .consumer       (consumer),
      .status_0       (status0),
      .status_1       (status1),
      .op_en_0        (opEn0),
      .op_en_1        (opEn1),
      .dp_start       (dpStart),
      .dp_group       (dpGroup),
      .dp_busy        (dpBusy),
      .intr_done      (intrDone),
      .done_cnt       (doneCnt),
      .err_unexp_done (errUnexp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model: group enables, consumer pointer and datapath activity
   bit mOpEn [2];
   bit mCons, mBusy, mStart, mErr;
   int mIntr, mCnt;

   typedef struct {
      int wr0, wr1, data, abort, done;
      int s0, s1, cons, o0, o1, st, busy, intr, cnt, err;
   } vec_t;
   vec_t vecs [10];

   task automatic check(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic modelReset();
      mOpEn[0] = 0; mOpEn[1] = 0;
      mCons = 0; mBusy = 0; mStart = 0; mErr = 0;
      mIntr = 0; mCnt = 0;
   endtask

   task automatic modelStep(input bit w0, input bit w1, input bit d, input bit ab, input bit dn);
      bit completing, launching;
      if (ab) begin
         modelReset();
         return;
      end
      completing = mBusy && !mStart && dn;
      launching  = !mBusy && mOpEn[mCons];
      mIntr = 0;
      if (dn && !completing) mErr = 1;
      if (completing) begin
         mOpEn[mCons] = 0;
         mIntr = mCons ? 2 : 1;
         mCons = !mCons;
         mCnt = (mCnt + 1) % CNT_MOD;
      end
      if (w0 && d) mOpEn[0] = 1;
      if (w1 && d) mOpEn[1] = 1;
      mBusy  = launching || (mBusy && !completing);
      mStart = launching;
   endtask

   function automatic int statusOf(input int g);
      if (!mOpEn[g]) return 0;
      return (int'(mCons) == g) ? 1 : 2;
   endfunction

   task automatic checkOutput();
      check("status_0", int'(status0), statusOf(0));
      check("status_1", int'(status1), statusOf(1));
      check("consumer", int'(consumer), int'(mCons));
      check("op_en_0", int'(opEn0), int'(mOpEn[0]));
      check("op_en_1", int'(opEn1), int'(mOpEn[1]));
      check("dp_start", int'(dpStart), int'(mStart));
      check("dp_busy", int'(dpBusy), int'(mBusy));
      check("dp_group", int'(dpGroup), int'(mCons));
      check("intr_done", int'(intrDone), mIntr);
      check("done_cnt", int'(doneCnt), mCnt);
      check("err_unexp_done", int'(errUnexp), int'(mErr));
   endtask

   // One clock cycle: drive inputs, advance the model at the edge, compare on negedge
   task automatic applyStimulus(input bit w0, input bit w1, input bit d, input bit ab, input bit dn);
      wr0 = w0; wr1 = w1; wrData = d; abortIn = ab; doneIn = dn;
      @(posedge clk);
      modelStep(w0, w1, d, ab, dn);
      @(negedge clk);
      checkOutput();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0);
   endtask

   initial begin
      bit prevCons;
      vecs[0] = '{1,0,1,0,0, 1,0,0,1,0,0,0,0,0,0};
      vecs[1] = '{0,0,0,0,0, 1,0,0,1,0,1,1,0,0,0};
      vecs[2] = '{0,1,1,0,0, 1,2,0,1,1,0,1,0,0,0};
      vecs[3] = '{0,0,0,0,0, 1,2,0,1,1,0,1,0,0,0};
      vecs[4] = '{0,0,0,0,1, 0,1,1,0,1,0,0,1,1,0};
      vecs[5] = '{0,0,0,0,0, 0,1,1,0,1,1,1,0,1,0};
      vecs[6] = '{0,0,0,0,1, 0,1,1,0,1,0,1,0,1,1};
      vecs[7] = '{0,0,0,0,1, 0,0,0,0,0,0,0,2,2,1};
      vecs[8] = '{1,0,0,0,0, 0,0,0,0,0,0,0,0,2,1};
      vecs[9] = '{0,0,0,1,0, 0,0,0,0,0,0,0,0,0,0};

      rstn = 1'b0;
      wr0 = 0; wr1 = 0; wrData = 0; abortIn = 0; doneIn = 0;
      modelReset();
      repeat (3) @(negedge clk);
      check("reset_consumer", int'(consumer), 0);
      check("reset_status_0", int'(status0), 0);
      check("reset_dp_busy", int'(dpBusy), 0);
      check("reset_done_cnt", int'(doneCnt), 0);
      rstn = 1'b1;
      @(negedge clk);

      // Directed vector table
      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i].wr0 != 0, vecs[i].wr1 != 0, vecs[i].data != 0,
                       vecs[i].abort != 0, vecs[i].done != 0);
         check($sformatf("vec%0d_status_0", i), int'(status0), vecs[i].s0);
         check($sformatf("vec%0d_status_1", i), int'(status1), vecs[i].s1);
         check($sformatf("vec%0d_consumer", i), int'(consumer), vecs[i].cons);
         check($sformatf("vec%0d_op_en_0", i), int'(opEn0), vecs[i].o0);
         check($sformatf("vec%0d_op_en_1", i), int'(opEn1), vecs[i].o1);
         check($sformatf("vec%0d_dp_start", i), int'(dpStart), vecs[i].st);
         check($sformatf("vec%0d_dp_busy", i), int'(dpBusy), vecs[i].busy);
         check($sformatf("vec%0d_intr_done", i), int'(intrDone), vecs[i].intr);
         check($sformatf("vec%0d_done_cnt", i), int'(doneCnt), vecs[i].cnt);
         check($sformatf("vec%0d_err", i), int'(errUnexp), vecs[i].err);
      end

      // Second group queued while the first runs, then back-to-back launch
      applyStimulus(1, 0, 1, 0, 0);
      idle(1);
      applyStimulus(0, 1, 1, 0, 0);
      check("t2_status_1_pending", int'(status1), 2);
      applyStimulus(0, 0, 0, 0, 1);
      check("t2_status_1_running", int'(status1), 1);
      idle(1);
      check("t2_dp_start_after_flip", int'(dpStart), 1);
      check("t2_dp_group", int'(dpGroup), 1);
      idle(1);
      applyStimulus(0, 0, 0, 0, 1);

      // Stray dp_done while idle
      applyStimulus(0, 0, 0, 1, 0);
      applyStimulus(0, 0, 0, 0, 1);
      check("t3_err_set", int'(errUnexp), 1);
      check("t3_cnt_unchanged", int'(doneCnt), 0);
      idle(2);
      check("t3_err_sticky", int'(errUnexp), 1);
      check("t3_still_idle", int'(dpBusy), 0);

      // Re-enable of the running group in its completion cycle
      applyStimulus(0, 0, 0, 1, 0);
      applyStimulus(1, 0, 1, 0, 0);
      idle(2);
      applyStimulus(1, 0, 1, 0, 1);
      check("t4_consumer", int'(consumer), 1);
      check("t4_status_0", int'(status0), 2);
      check("t4_op_en_0", int'(opEn0), 1);
      idle(2);

      // Abort mid-layer with both groups enabled
      applyStimulus(0, 0, 0, 1, 0);
      applyStimulus(1, 1, 1, 0, 0);
      idle(2);
      applyStimulus(0, 0, 0, 1, 0);
      check("t5_status_0", int'(status0), 0);
      check("t5_status_1", int'(status1), 0);
      check("t5_consumer", int'(consumer), 0);
      check("t5_done_cnt", int'(doneCnt), 0);
      for (int i = 0; i < 4; i++) begin
         idle(1);
         check("t5_no_start", int'(dpStart), 0);
      end

      // Counter wrap over 2^CNT_W + 1 layers
      for (int layer = 0; layer <= CNT_MOD; layer++) begin
         prevCons = consumer;
         applyStimulus(!mCons, mCons, 1, 0, 0);
         for (int k = 0; k < 8 && !dpStart; k++) idle(1);
         check("t6_layer_start", int'(dpStart), 1);
         idle(1);
         applyStimulus(0, 0, 0, 0, 1);
         check("t6_consumer_alternates", int'(consumer), int'(!prevCons));
      end
      check("t6_done_cnt_wrapped", int'(doneCnt), 1);

      // Asynchronous reset in the middle of a layer
      applyStimulus(1, 0, 1, 0, 0);
      idle(2);
      rstn = 1'b0;
      #1;
      modelReset();
      check("async_rst_busy", int'(dpBusy), 0);
      check("async_rst_status_0", int'(status0), 0);
      check("async_rst_done_cnt", int'(doneCnt), 0);
      check("async_rst_consumer", int'(consumer), 0);
      @(negedge clk);
      rstn = 1'b1;
      idle(1);

      // Random traffic against the model
      for (int i = 0; i < 600; i++) begin
         applyStimulus(($urandom % 8) == 0, ($urandom % 8) == 0, ($urandom % 4) != 0,
                       ($urandom % 64) == 0, ($urandom % 5) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
